// File: rtl/sel_scan_pkg.sv
// Shared types and helpers for the SEL_4_1 channel-scan controller.
// The channel-pick functions are used by both the start and advance paths.
package sel_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Lowest enabled channel strictly above cur.
  function automatic ch_pick_t next_ch(input logic [NUM_CH-1:0] mask,
                                       input logic [SEL_W-1:0]  cur);
    ch_pick_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        r.found = 1'b1;
        r.ch    = SEL_W'(i);
      end
    end
    return r;
  endfunction

  // Lowest enabled channel overall (channel 0 included).
  function automatic ch_pick_t first_ch(input logic [NUM_CH-1:0] mask);
    ch_pick_t r;
    r = next_ch(mask, '0);
    if (mask[0]) begin
      r.found = 1'b1;
      r.ch    = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_dwell_timer.sv
// Settle-time counter: load a value, count down to zero, flag zero.
// Holds at zero so a stray decrement cannot wrap.
module sel_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sel_scan_ctrl.sv
// Sweeps the 4:1 selector through the enabled channels, settling DWELL cycles
// on each before sampling, and publishes each completed sweep with a VALID strobe.
module sel_scan_ctrl
  import sel_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              CONT,
  input  logic [NUM_CH-1:0] CH_MASK,
  input  logic              MUX_IN,
  output logic [SEL_W-1:0]  SEL,
  output logic [NUM_CH-1:0] DATA,
  output logic              VALID,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

  state_t            state, state_n;
  logic [NUM_CH-1:0] mask_q, shadow, shadow_upd;
  logic [SEL_W-1:0]  sel_q;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              start_ok, relaunch, abort;
  ch_pick_t          nxt, first;

  assign nxt      = next_ch(mask_q, sel_q);
  assign first    = first_ch(CH_MASK);
  assign start_ok = START && !STOP && (CH_MASK != '0);
  assign relaunch = CONT && (CH_MASK != '0);
  assign abort    = STOP && (state != ST_IDLE);

  always_comb begin
    shadow_upd        = shadow;
    shadow_upd[sel_q] = MUX_IN;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state; STOP outranks every other exit, including DONE entry
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_ok) state_n = ST_SETTLE;
        ST_SETTLE: if (tmr_zero) state_n = ST_SAMPLE;
        ST_SAMPLE: state_n = nxt.found ? ST_SETTLE : ST_DONE;
        ST_DONE:   state_n = relaunch ? ST_SETTLE : ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs and timer controls
  always_comb begin
    BUSY     = (state != ST_IDLE);
    VALID    = (state == ST_DONE);
    tmr_dec  = (state == ST_SETTLE);
    tmr_load = (state_n == ST_SETTLE) && (state != ST_SETTLE);
  end

  sel_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (DWELL_LD),
    .zero     (tmr_zero)
  );

  // Datapath: channel select, sweep mask, partial sample word, published word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_q  <= '0;
      mask_q <= '0;
      shadow <= '0;
      DATA   <= '0;
    end else if (abort) begin
      sel_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_ok) begin
          mask_q <= CH_MASK;
          shadow <= '0;
          sel_q  <= first.ch;
        end
        ST_SAMPLE: begin
          shadow <= shadow_upd;
          if (nxt.found) sel_q <= nxt.ch;
          else           DATA  <= shadow_upd;
        end
        ST_DONE: if (relaunch) begin
          mask_q <= CH_MASK;
          shadow <= '0;
          sel_q  <= first.ch;
        end
        default: ;
      endcase
    end
  end

  assign SEL = sel_q;

endmodule
